serv_rd_collect: RTL and testbench
==================================

// Module: serv_rd_collect
// PURPOSE
//  Bit-serial result collector directly downstream of the serial ALU.
//  Consumes the LSB-first o_rd/o_cmp stream, deserialises 32 bits into a word and issues
//  a single register-file write with a req/ack handshake.
//  Also latches the final compare bit for the branch/SLT logic.
//  Sits between serv_alu and the register-file write port.
// PARAMETERS
//  XLEN   32  result word width; bits consumed per operation
//  RF_AW  5   register-file address width
// PORTS
//  clk        in   1      clock, rising edge
//  i_rst      in   1      reset, asynchronous, active-high
//  i_start    in   1      begin collecting; sampled only in IDLE
//  i_rd_addr  in   RF_AW  destination register, latched on accepted i_start
//  i_rd_we    in   1      write enable for this op, latched on accepted i_start
//  i_abort    in   1      synchronous abort; return to IDLE, no write
//  i_en       in   1      ALU bit valid this cycle (same as ALU i_en)
//  i_rd       in   1      ALU serial result bit (ALU o_rd)
//  i_cmp      in   1      ALU compare bit (ALU o_cmp)
//  o_ready    out  1      1 in IDLE
//  o_wreq     out  1      register-file write request
//  o_waddr    out  RF_AW  write address, stable while o_wreq
//  o_wdata    out  XLEN   write data, stable while o_wreq
//  o_wpar     out  1      even parity of o_wdata (see CONFIGURATION)
//  i_wack     in   1      register-file accepts write this cycle
//  o_cmp      out  1      compare bit captured on the last stream bit
//  o_done     out  1      one-cycle pulse on each return to IDLE other than via abort/reset
// BEHAVIOUR
//  Reset values: state=IDLE, count=0, shreg=0, o_ready=1, o_wreq=0, o_waddr=0, o_wdata=0,
//    o_wpar=0, o_cmp=0, o_done=0.
//  FSM IDLE/SHIFT/WRITE:
//  - IDLE: on i_start, latch addr/we, clear count and shreg, then go to SHIFT next cycle.
//    i_en is ignored.
//  - SHIFT: each cycle with i_en=1: shreg <= {i_rd, shreg[XLEN-1:1]}; count++.
//    Cycles with i_en=0 hold state.
//  - Last bit (count==XLEN-1 && i_en): o_cmp <= i_cmp.
//    - If we && addr!=0, go to WRITE.
//    - Otherwise go to IDLE with o_done=1 the next cycle. Writes to x0 are suppressed.
//  - WRITE: o_wreq=1; o_waddr/o_wdata are registered and held until the i_wack cycle.
//    On i_wack, go to IDLE; o_wreq=0 and o_done=1 the next cycle.
//  Latency: o_wreq rises the cycle after the 32nd enabled bit. Back-to-back ops need one
//    IDLE cycle.
//  Word count wraps 5'd31->0 only via the state change; it never free-runs.
//  i_start outside IDLE is ignored, including when it coincides with i_wack.
//  i_abort is valid in any state and has priority over i_en/i_wack/i_start:
//    - go to IDLE, o_wreq drops next cycle, no o_done;
//    - o_cmp holds its previous value.
//  i_wack while not in WRITE is ignored.
//  Reset mid-op: immediate IDLE, pending write discarded.
// CONFIGURATION
//  SERV_RD_PARITY_EN defined:
//    - parity accumulated serially: par ^= i_rd per enabled bit, cleared on start;
//    - o_wpar is valid with o_wreq and held with o_wdata.
//  Not defined: o_wpar tied 0, no accumulator flop.
// STRUCTURE
//  Package serv_rd_pkg holds:
//    - state enum (IDLE, SHIFT, WRITE);
//    - XLEN default and CNT_W=$clog2(XLEN);
//    - X0_ADDR constant.
//  Sub-module serv_rd_shreg: shift register + bit counter + last-bit flag (+ parity when
//    enabled). The FSM and handshake stay in the top.
// TESTING
//  1. start addr=5 we=1, stream 0xDEADBEEF LSB-first with i_en=1 continuous, i_cmp=1 on
//     the last bit -> o_wreq next cycle, waddr=5, wdata=0xDEADBEEF, o_cmp=1;
//     i_wack -> o_done pulse, o_ready=1.
//  2. Same stream with i_en gaps (every 3rd cycle 0) -> identical wdata; o_wreq only after
//     the 32nd enabled bit.
//  3. addr=0 we=1, or addr=7 we=0, stream 0xFFFFFFFF -> no o_wreq; o_done the cycle after
//     the last bit.
//  4. Hold i_wack=0 for 10 cycles in WRITE with i_start=1 -> o_wreq/addr/data stable,
//     start ignored; ack -> IDLE.
//  5. i_abort after 17 bits, then new op addr=3 data 0x00000001 -> only one write
//     (3, 0x1), no o_done for the aborted op.
//  6. Assert i_rst mid-SHIFT and mid-WRITE -> all outputs at reset values asynchronously.
//     With SERV_RD_PARITY_EN, data 0x00000007 -> o_wpar=1.

Source files
------------

// File: rtl/serv_rd_pkg.sv
// Shared types and constants for the serial result collector.
// Holds the collector state encoding, the default word width, the bit-counter
// width and the address of the hard-wired zero register.
package serv_rd_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RF_AW_DEF = 5;
    localparam int CNT_W     = $clog2(XLEN_DEF);

    // Register x0 always reads zero, so writes to it are dropped.
    localparam logic [RF_AW_DEF-1:0] X0_ADDR = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/serv_rd_shreg.sv
// Deserialiser for the LSB-first ALU result stream.
// Shifts one bit in per enabled cycle, counts bits and flags the last one.
// Optional feature macro: SERV_RD_PARITY_EN adds a serial parity accumulator;
// without it par_o is tied low and no accumulator flop exists.
module serv_rd_shreg
    import serv_rd_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            shift_i,
    input  logic            bit_i,
    output logic [XLEN-1:0] word_o,
    output logic            last_o,
    output logic            par_o
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] shreg_q;
    logic [CW-1:0]   count_q;

    // The bit that arrives while count sits at XLEN-1 completes the word.
    assign last_o = (count_q == CW'(XLEN - 1));
    assign word_o = shreg_q;

    // Shift register and bit counter; the counter is returned to zero on the
    // last bit and on every accepted start, never by free-running.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (shift_i) begin
            shreg_q <= {bit_i, shreg_q[XLEN-1:1]};
            count_q <= last_o ? '0 : count_q + 1'b1;
        end
    end

`ifdef SERV_RD_PARITY_EN
    logic par_q;

    assign par_o = par_q;

    // Running even parity of every bit shifted in since the last start.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            par_q <= 1'b0;
        end else if (clear_i) begin
            par_q <= 1'b0;
        end else if (shift_i) begin
            par_q <= par_q ^ bit_i;
        end
    end
`else
    assign par_o = 1'b0;
`endif

endmodule

// File: rtl/serv_rd_collect.sv
// Bit-serial result collector sitting between serv_alu and the register-file
// write port. Collects XLEN LSB-first result bits, then issues one write with
// a req/ack handshake and latches the final compare bit.
// Optional feature macro: SERV_RD_PARITY_EN (even parity on o_wpar).
//
// Write handshake: o_wreq is held high with o_waddr/o_wdata/o_wpar stable
// until the cycle i_wack is sampled high; that cycle completes the transfer
// and o_wreq is low on the following cycle. i_abort in the same cycle takes
// priority and cancels the transfer.
module serv_rd_collect
    import serv_rd_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RF_AW = RF_AW_DEF
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [RF_AW-1:0] i_rd_addr,
    input  logic             i_rd_we,
    input  logic             i_abort,
    input  logic             i_en,
    input  logic             i_rd,
    input  logic             i_cmp,
    output logic             o_ready,
    output logic             o_wreq,
    output logic [RF_AW-1:0] o_waddr,
    output logic [XLEN-1:0]  o_wdata,
    output logic             o_wpar,
    input  logic             i_wack,
    output logic             o_cmp,
    output logic             o_done,
    output state_t           o_state
);

    state_t           state_q;
    logic             ready_q;
    logic             wreq_q;
    logic [RF_AW-1:0] waddr_q;
    logic [XLEN-1:0]  wdata_q;
    logic             cmp_q;
    logic             done_q;
    logic [RF_AW-1:0] addr_q;
    logic             we_q;

    logic             start_acc;
    logic             shift_en;
    logic             last_bit;
    logic             write_go;
    logic [XLEN-1:0]  word;
    logic [XLEN-1:0]  full_word;
    logic             last_flag;
    logic             par;

    // Abort wins over everything, so it also blocks a start and any shift.
    assign start_acc = (state_q == ST_IDLE) && i_start && !i_abort;
    assign shift_en  = (state_q == ST_SHIFT) && i_en && !i_abort;
    assign last_bit  = shift_en && last_flag;
    assign write_go  = we_q && (addr_q != RF_AW'(X0_ADDR));

    // The final bit is folded in here so the write data is registered on the
    // same edge that consumes it, giving o_wreq one cycle after the last bit.
    assign full_word = {i_rd, word[XLEN-1:1]};

    serv_rd_shreg #(
        .XLEN (XLEN)
    ) u_shreg (
        .clk     (clk),
        .rst_i   (i_rst),
        .clear_i (start_acc),
        .shift_i (shift_en),
        .bit_i   (i_rd),
        .word_o  (word),
        .last_o  (last_flag),
        .par_o   (par)
    );

    // Collector FSM with all handshake outputs registered.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            wreq_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cmp_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_abort) begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
                wreq_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_start) begin
                            addr_q  <= i_rd_addr;
                            we_q    <= i_rd_we;
                            ready_q <= 1'b0;
                            state_q <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (last_bit) begin
                            cmp_q <= i_cmp;
                            if (write_go) begin
                                state_q <= ST_WRITE;
                                wreq_q  <= 1'b1;
                                waddr_q <= addr_q;
                                wdata_q <= full_word;
                            end else begin
                                state_q <= ST_IDLE;
                                ready_q <= 1'b1;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (i_wack) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                            wreq_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        wreq_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SERV_RD_PARITY_EN
    logic wpar_q;

    // Parity is captured alongside the write data and held with it.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wpar_q <= 1'b0;
        end else if (last_bit && write_go) begin
            wpar_q <= par ^ i_rd;
        end
    end

    assign o_wpar = wpar_q;
`else
    logic unused_par;
    assign unused_par = par;
    assign o_wpar     = 1'b0;
`endif

    assign o_ready = ready_q;
    assign o_wreq  = wreq_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    assign o_cmp   = cmp_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_serv_rd_collect.sv
// Bench for serv_rd_collect: directed scenarios followed by randomized ops,
// checked against a transaction-level model and a write scoreboard.
module tb_serv_rd_collect;
    import serv_rd_pkg::*;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [RF_AW-1:0] i_rd_addr = '0;
    logic             i_rd_we = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_en = 1'b0;
    logic             i_rd = 1'b0;
    logic             i_cmp = 1'b0;
    logic             i_wack = 1'b0;
    logic             o_ready;
    logic             o_wreq;
    logic [RF_AW-1:0] o_waddr;
    logic [XLEN-1:0]  o_wdata;
    logic             o_wpar;
    logic             o_cmp;
    logic             o_done;
    state_t           o_state;

    always #5 clk = ~clk;

    serv_rd_collect #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_rd_addr (i_rd_addr),
        .i_rd_we   (i_rd_we),
        .i_abort   (i_abort),
        .i_en      (i_en),
        .i_rd      (i_rd),
        .i_cmp     (i_cmp),
        .o_ready   (o_ready),
        .o_wreq    (o_wreq),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata),
        .o_wpar    (o_wpar),
        .i_wack    (i_wack),
        .o_cmp     (o_cmp),
        .o_done    (o_done),
        .o_state   (o_state)
    );

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [RF_AW+XLEN-1:0] exp_q[$];
    logic [RF_AW+XLEN-1:0] got_q[$];
    logic last_cmp = 1'b0;

    // Every completed write transfer seen on the port.
    always @(posedge clk) begin
        if (!i_rst && o_wreq && i_wack && !i_abort)
            got_q.push_back({o_waddr, o_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [XLEN-1:0] d);
`ifdef SERV_RD_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, o_ready, 1);
        check({tag, "_wreq"},  o_wreq, 0);
        check({tag, "_waddr"}, o_waddr, 0);
        check({tag, "_wdata"}, o_wdata, 0);
        check({tag, "_wpar"},  o_wpar, 0);
        check({tag, "_cmp"},   o_cmp, 0);
        check({tag, "_done"},  o_done, 0);
        check({tag, "_state"}, o_state, ST_IDLE);
    endtask

    // Abort (with every competing input asserted) or asynchronous reset mid-op.
    task automatic interrupt(input bit use_rst, input string tag);
        if (!use_rst) begin
            i_abort = 1'b1; i_en = 1'b1; i_wack = 1'b1; i_start = 1'b1; i_cmp = ~last_cmp;
            step();
            i_abort = 1'b0; i_en = 1'b0; i_wack = 1'b0; i_start = 1'b0;
            check({tag, "_abort_ready"}, o_ready, 1);
            check({tag, "_abort_wreq"},  o_wreq, 0);
            check({tag, "_abort_done"},  o_done, 0);
            check({tag, "_abort_cmp"},   o_cmp, last_cmp);
            step();
            check({tag, "_abort_done2"}, o_done, 0);
            check({tag, "_abort_state"}, o_state, ST_IDLE);
        end else begin
            #2;
            i_rst = 1'b1;
            #1;
            check_reset_vals({tag, "_rst"});
            last_cmp = 1'b0;
            @(posedge clk);
            #1;
            i_rst = 1'b0;
        end
    endtask

    // One op: gap_mode 0 = continuous, 1 = every 3rd cycle idle, 2 = random gaps.
    // intr_at < 0: none; 0..31: interrupt after that many bits; 32: in WRITE.
    task automatic do_op(input logic [RF_AW-1:0] addr, input bit we, input logic [XLEN-1:0] data,
                         input int gap_mode, input bit cmp_last, input int ack_delay,
                         input bit start_in_write, input int intr_at, input bit intr_rst,
                         input string tag);
        int  bits;
        int  cyc;
        bit  en;
        bit  exp_write;
        exp_write = we && (addr != 0);
        check({tag, "_ready_pre"}, o_ready, 1);
        i_start = 1'b1; i_rd_addr = addr; i_rd_we = we;
        step();
        i_start = 1'b0; i_rd_addr = $urandom_range(0, 31); i_rd_we = $urandom_range(0, 1);
        check({tag, "_ready_busy"}, o_ready, 0);
        bits = 0;
        cyc = 0;
        while (bits < XLEN) begin
            if (intr_at == bits) begin
                interrupt(intr_rst, tag);
                return;
            end
            if (cyc > 400) begin
                check({tag, "_stream_timeout"}, 1, 0);
                return;
            end
            case (gap_mode)
                1:       en = (cyc % 3) != 2;
                2:       en = $urandom_range(0, 3) != 0;
                default: en = 1'b1;
            endcase
            i_en  = en;
            i_rd  = en ? data[bits] : $urandom_range(0, 1);
            i_cmp = (en && bits == XLEN - 1) ? cmp_last : ~cmp_last;
            i_start = $urandom_range(0, 1);
            step();
            cyc++;
            if (en) bits++;
            if (bits < XLEN) begin
                check({tag, "_wreq_early"}, o_wreq, 0);
                check({tag, "_done_early"}, o_done, 0);
            end
        end
        i_en = 1'b0;
        i_start = 1'b0;
        last_cmp = cmp_last;
        check({tag, "_cmp"}, o_cmp, cmp_last);
        if (exp_write) begin
            check({tag, "_wreq"},  o_wreq, 1);
            check({tag, "_waddr"}, o_waddr, addr);
            check({tag, "_wdata"}, o_wdata, data);
            check({tag, "_wpar"},  o_wpar, exp_parity(data));
            check({tag, "_done_w"}, o_done, 0);
            if (intr_at == XLEN) begin
                interrupt(intr_rst, {tag, "_w"});
                return;
            end
            exp_q.push_back({addr, data});
            for (int k = 0; k < ack_delay; k++) begin
                i_start = start_in_write;
                step();
                check({tag, "_hold_wreq"},  o_wreq, 1);
                check({tag, "_hold_waddr"}, o_waddr, addr);
                check({tag, "_hold_wdata"}, o_wdata, data);
                check({tag, "_hold_ready"}, o_ready, 0);
            end
            i_wack = 1'b1;
            i_start = start_in_write;
            step();
            i_wack = 1'b0;
            i_start = 1'b0;
            check({tag, "_ack_wreq"},  o_wreq, 0);
            check({tag, "_ack_done"},  o_done, 1);
            check({tag, "_ack_ready"}, o_ready, 1);
        end else begin
            check({tag, "_nowr_wreq"},  o_wreq, 0);
            check({tag, "_nowr_done"},  o_done, 1);
            check({tag, "_nowr_ready"}, o_ready, 1);
        end
        check({tag, "_cmp_post"}, o_cmp, cmp_last);
        step();
        check({tag, "_done_clr"}, o_done, 0);
        check({tag, "_state_idle"}, o_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        step();
        check_reset_vals("idle");

        do_op(5'd5, 1'b1, 32'hDEADBEEF, 0, 1'b1, 0, 1'b0, -1, 1'b0, "t1");
        do_op(5'd5, 1'b1, 32'hDEADBEEF, 1, 1'b0, 0, 1'b0, -1, 1'b0, "t2_gaps");
        do_op(5'd0, 1'b1, 32'hFFFFFFFF, 0, 1'b1, 0, 1'b0, -1, 1'b0, "t3_x0");
        do_op(5'd7, 1'b0, 32'hFFFFFFFF, 0, 1'b0, 0, 1'b0, -1, 1'b0, "t3_nowe");
        do_op(5'd12, 1'b1, 32'h8000_0001, 0, 1'b1, 10, 1'b1, -1, 1'b0, "t4_hold");
        do_op(5'd9, 1'b1, 32'h1234_5678, 0, 1'b0, 0, 1'b0, 17, 1'b0, "t5_abort");
        do_op(5'd3, 1'b1, 32'h0000_0001, 0, 1'b0, 0, 1'b0, -1, 1'b0, "t5_next");
        do_op(5'd14, 1'b1, 32'hCAFE_F00D, 2, 1'b1, 2, 1'b0, 32, 1'b0, "t5_abort_w");
        do_op(5'd21, 1'b1, 32'h0000_0007, 0, 1'b1, 1, 1'b0, -1, 1'b0, "t6_par7");

        for (int n = 0; n < 12; n++) begin
            do_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom,
                  2, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                  -1, 1'b0, "rand");
        end

        do_op(5'd6, 1'b1, 32'hA5A5_5A5A, 0, 1'b1, 0, 1'b0, 10, 1'b1, "t6_rst_shift");
        do_op(5'd8, 1'b1, 32'h0F0F_F0F0, 0, 1'b1, 0, 1'b0, 32, 1'b1, "t6_rst_write");
        do_op(5'd2, 1'b1, 32'h0000_0007, 0, 1'b0, 0, 1'b0, -1, 1'b0, "post_rst");

        // Final scoreboard reconciliation of completed writes.
        check("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("wr_entry", got_q[i], exp_q[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
